npc_ras: RTL and testbench

Parametrised next-PC generator with an owned PC register and a return-address stack (RAS). Sits at the front of the fetch stage: it holds the current PC, computes sequential, branch, jump, jump-and-link and jump-register targets, and predicts return addresses for `jr $ra`. The decode stage drives the operation select and operands. The block flags return mispredictions so the pipeline can redirect.

---
 rtl/npc_ras_pkg.sv | 25 ++
 rtl/npc_ras_ras_stack.sv | 79 +++++++
 rtl/npc_ras.sv | 110 +++++++++++
 tb/tb_npc_ras.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/npc_ras_pkg.sv
// npc_ras_pkg: shared constants for the next-PC generator.
//   NPC_* : operation select encodings driven by decode on npc_op.
//   NPC_RESET_PC : default PC after reset.
package npc_ras_pkg;

  localparam logic [2:0] NPC_SEQ = 3'd0;
  localparam logic [2:0] NPC_BR  = 3'd1;
  localparam logic [2:0] NPC_J   = 3'd2;
  localparam logic [2:0] NPC_JAL = 3'd3;
  localparam logic [2:0] NPC_JR  = 3'd4;
  localparam logic [2:0] NPC_RET = 3'd5;

  localparam logic [31:0] NPC_RESET_PC = 32'h0000_3000;

  // Returns 1 when the op writes a link onto the return-address stack.
  function automatic logic npc_is_push(input logic [2:0] op);
    return (op == NPC_JAL);
  endfunction

  // Returns 1 when the op consumes the top of the return-address stack.
  function automatic logic npc_is_pop(input logic [2:0] op);
    return (op == NPC_RET);
  endfunction

endpackage

// File: rtl/npc_ras_ras_stack.sv
// ras_stack: circular return-address stack.
//   clk, reset      : clock, synchronous active-high reset (clears sp/count/overflow only)
//   push, pop       : one-cycle enables, already qualified by the caller's hold condition
//   push_data       : link address written on push
//   top             : current top of stack, 0 when empty
//   count           : number of valid entries (0..DEPTH)
//   overflow        : sticky, set when a push overwrites the oldest entry
module ras_stack #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           push_data,
  output logic [WIDTH-1:0]           top,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    sp_q;
  logic [CW-1:0]    count_q;
  logic             overflow_q;
  logic             full_s;
  logic             empty_s;
  logic [AW-1:0]    sp_inc_s;

  assign full_s   = (count_q == CW'(DEPTH));
  assign empty_s  = (count_q == {CW{1'b0}});
  // DEPTH is a power of two, so pointer arithmetic wraps naturally.
  assign sp_inc_s = sp_q + AW'(1);

  // Top-of-stack read; an empty stack reports zero rather than stale storage.
  always_comb begin
    top = {WIDTH{1'b0}};
    if (!empty_s) begin
      top = mem_q[sp_q];
    end else begin
      top = {WIDTH{1'b0}};
    end
  end

  // Pointer, occupancy and sticky overflow; reset wins over any push or pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q       <= {AW{1'b0}};
      count_q    <= {CW{1'b0}};
      overflow_q <= 1'b0;
    end else if (push) begin
      sp_q <= sp_inc_s;
      if (full_s) begin
        overflow_q <= 1'b1;
      end else begin
        count_q <= count_q + CW'(1);
      end
    end else if (pop && !empty_s) begin
      sp_q    <= sp_q - AW'(1);
      count_q <= count_q - CW'(1);
    end else begin
      sp_q <= sp_q;
    end
  end

  // Storage is deliberately not reset; only the entry above sp is written on push.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem_q[sp_inc_s] <= push_data;
    end
  end

  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/npc_ras.sv
// npc_ras: next-PC generator with owned PC register and return-address stack.
//   clk, reset      : clock, synchronous active-high reset
//   stall           : hold PC and RAS state this cycle
//   npc_op          : operation select (NPC_* in npc_ras_pkg)
//   br_taken        : branch condition, only meaningful for NPC_BR
//   imm26           : jump immediate; [15:0] is the branch offset
//   rs_val          : register target for NPC_JR / NPC_RET
//   pc, pc4         : current PC (registered) and pc+4
//   next_pc         : PC value taken at the next unstalled edge
//   ret_pred        : RAS top (0 when empty)
//   ret_mispredict  : NPC_RET with empty stack or ret_pred != rs_val
//   ras_count       : valid RAS entries
//   ras_overflow    : sticky RAS overflow flag
module npc_ras
  import npc_ras_pkg::*;
#(
  parameter int          WIDTH     = 32,
  parameter logic [31:0] RESET_PC  = NPC_RESET_PC,
  parameter int          RAS_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         stall,
  input  logic [2:0]                   npc_op,
  input  logic                         br_taken,
  input  logic [25:0]                  imm26,
  input  logic [WIDTH-1:0]             rs_val,
  output logic [WIDTH-1:0]             pc,
  output logic [WIDTH-1:0]             pc4,
  output logic [WIDTH-1:0]             next_pc,
  output logic [WIDTH-1:0]             ret_pred,
  output logic                         ret_mispredict,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_overflow
);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] br_off_s;
  logic [WIDTH-1:0] jmp_tgt_s;
  logic             push_s;
  logic             pop_s;

  assign pc4       = pc_q + WIDTH'(4);
  assign br_off_s  = {{(WIDTH-18){imm26[15]}}, imm26[15:0], 2'b00};
  assign jmp_tgt_s = {pc4[WIDTH-1:28], imm26, 2'b00};

  // Target select; unused codes fall through to sequential.
  always_comb begin
    pc_d = pc4;
    case (npc_op)
      NPC_SEQ: pc_d = pc4;
      NPC_BR: begin
        if (br_taken) begin
          pc_d = pc4 + br_off_s;
        end else begin
          pc_d = pc4;
        end
      end
      NPC_J:   pc_d = jmp_tgt_s;
      NPC_JAL: pc_d = jmp_tgt_s;
      NPC_JR:  pc_d = rs_val;
      NPC_RET: pc_d = rs_val;
      default: pc_d = pc4;
    endcase
  end

  // Stall freezes the stack; reset is handled inside the stack and wins.
  assign push_s = npc_is_push(npc_op) && !stall;
  assign pop_s  = npc_is_pop(npc_op) && !stall;

  ras_stack #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .pop       (pop_s),
    .push_data (pc4),
    .top       (ret_pred),
    .count     (ras_count),
    .overflow  (ras_overflow)
  );

  // Mispredict uses the pre-pop top; an empty stack always mispredicts.
  always_comb begin
    ret_mispredict = 1'b0;
    if (npc_is_pop(npc_op)) begin
      ret_mispredict = (ras_count == '0) || (ret_pred != rs_val);
    end else begin
      ret_mispredict = 1'b0;
    end
  end

  // PC register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= WIDTH'(RESET_PC);
    end else if (!stall) begin
      pc_q <= pc_d;
    end else begin
      pc_q <= pc_q;
    end
  end

  assign pc      = pc_q;
  assign next_pc = pc_d;

endmodule

// File: tb/tb_npc_ras.sv
module tb_npc_ras;

  logic        clk = 1'b0;
  logic        reset, stall, br_taken;
  logic [2:0]  npc_op;
  logic [25:0] imm26;
  logic [31:0] rs_val;
  logic [31:0] pc, pc4, next_pc, ret_pred;
  logic        ret_mispredict, ras_overflow;
  logic [3:0]  ras_count;

  int checks = 0;
  int failures = 0;

  // reference model state
  logic [31:0] m_pc;
  logic [31:0] m_stk[$];
  bit          m_ovf;

  npc_ras dut (
    .clk(clk), .reset(reset), .stall(stall), .npc_op(npc_op), .br_taken(br_taken),
    .imm26(imm26), .rs_val(rs_val), .pc(pc), .pc4(pc4), .next_pc(next_pc),
    .ret_pred(ret_pred), .ret_mispredict(ret_mispredict), .ras_count(ras_count),
    .ras_overflow(ras_overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] m_top();
    return (m_stk.size() == 0) ? 32'd0 : m_stk[$];
  endfunction

  function automatic logic [31:0] m_target();
    logic [31:0] seq;
    int signed off;
    seq = m_pc + 32'd4;
    off = int'($signed(imm26[15:0])) * 4;
    case (npc_op)
      3'd1: return br_taken ? seq + 32'(off) : seq;
      3'd2, 3'd3: return (seq & 32'hF000_0000) | (32'(imm26) * 32'd4);
      3'd4, 3'd5: return rs_val;
      default: return seq;
    endcase
  endfunction

  function automatic bit m_mispred();
    return (npc_op == 3'd5) && (m_stk.size() == 0 || m_top() != rs_val);
  endfunction

  task automatic model_commit();
    logic [31:0] tgt;
    tgt = m_target();
    if (reset) begin
      m_pc = 32'h3000; m_stk.delete(); m_ovf = 1'b0;
    end else if (!stall) begin
      if (npc_op == 3'd3) begin
        if (m_stk.size() == 8) begin void'(m_stk.pop_front()); m_ovf = 1'b1; end
        m_stk.push_back(m_pc + 32'd4);
      end else if (npc_op == 3'd5 && m_stk.size() > 0) begin
        void'(m_stk.pop_back());
      end
      m_pc = tgt;
    end
  endtask

  task automatic drive(input logic [2:0] o, input logic t, input logic [25:0] im,
                       input logic [31:0] rs, input logic st, input logic rst);
    npc_op = o; br_taken = t; imm26 = im; rs_val = rs; stall = st; reset = rst;
    #1;
  endtask

  task automatic tick();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(3'd0, 1'b0, 26'd0, 32'd0, 1'b0, 1'b1); tick(); tick();
    checks++; if (pc !== 32'h3000) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h3000); end
    checks++; if (ras_count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", ras_count); end
    checks++; if (ras_overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ras_overflow); end
    checks++; if (ret_pred !== 32'd0) begin failures++; $display("FAIL reset_retpred got=%h exp=0", ret_pred); end
  endtask

  task automatic test_seq_stall();
    logic [31:0] exp;
    for (int i = 0; i < 3; i++) begin
      drive(3'd0, 1'b0, 26'd0, 32'd0, 1'b0, 1'b0);
      exp = 32'h3000 + 32'(4 * i);
      checks++; if (pc !== exp) begin failures++; $display("FAIL seq_pc%0d got=%h exp=%h", i, pc, exp); end
      checks++; if (pc4 !== exp + 32'd4) begin failures++; $display("FAIL seq_pc4 got=%h exp=%h", pc4, exp + 32'd4); end
      tick();
    end
    checks++; if (pc !== 32'h300C) begin failures++; $display("FAIL seq_end got=%h exp=300c", pc); end
    for (int i = 0; i < 2; i++) begin
      drive(3'd0, 1'b0, 26'd0, 32'd0, 1'b1, 1'b0);
      checks++; if (next_pc !== 32'h3010) begin failures++; $display("FAIL stall_npc got=%h exp=3010", next_pc); end
      tick();
      checks++; if (pc !== 32'h300C) begin failures++; $display("FAIL stall_hold got=%h exp=300c", pc); end
    end
  endtask

  task automatic test_branch();
    drive(3'd0, 1'b0, 26'd0, 32'd0, 1'b0, 1'b0); tick();
    drive(3'd1, 1'b1, 26'h000FFFF, 32'd0, 1'b0, 1'b0);
    checks++; if (next_pc !== 32'h3010) begin failures++; $display("FAIL br_back_npc got=%h exp=3010", next_pc); end
    tick();
    checks++; if (pc !== 32'h3010) begin failures++; $display("FAIL br_back got=%h exp=3010", pc); end
    drive(3'd1, 1'b0, 26'h000FFFF, 32'd0, 1'b0, 1'b0); tick();
    checks++; if (pc !== 32'h3014) begin failures++; $display("FAIL br_nt got=%h exp=3014", pc); end
    drive(3'd1, 1'b1, 26'h0000004, 32'd0, 1'b0, 1'b0); tick();
    checks++; if (pc !== 32'h3028) begin failures++; $display("FAIL br_fwd got=%h exp=3028", pc); end
  endtask

  task automatic test_jumps();
    drive(3'd4, 1'b0, 26'd0, 32'h3000, 1'b0, 1'b0); tick();
    checks++; if (pc !== 32'h3000) begin failures++; $display("FAIL jr got=%h exp=3000", pc); end
    drive(3'd2, 1'b0, 26'h0000C10, 32'd0, 1'b0, 1'b0); tick();
    checks++; if (pc !== 32'h3040) begin failures++; $display("FAIL j got=%h exp=3040", pc); end
    checks++; if (ras_count !== 4'd0) begin failures++; $display("FAIL j_nopush got=%0d exp=0", ras_count); end
    drive(3'd4, 1'b0, 26'd0, 32'h3000, 1'b0, 1'b0); tick();
    drive(3'd3, 1'b0, 26'h0000C10, 32'd0, 1'b0, 1'b0); tick();
    checks++; if (pc !== 32'h3040) begin failures++; $display("FAIL jal got=%h exp=3040", pc); end
    checks++; if (ras_count !== 4'd1) begin failures++; $display("FAIL jal_count got=%0d exp=1", ras_count); end
    checks++; if (ret_pred !== 32'h3004) begin failures++; $display("FAIL jal_pred got=%h exp=3004", ret_pred); end
    drive(3'd5, 1'b0, 26'd0, 32'h3004, 1'b0, 1'b0);
    checks++; if (ret_mispredict !== 1'b0) begin failures++; $display("FAIL ret_ok_mp got=%b exp=0", ret_mispredict); end
    tick();
    checks++; if (pc !== 32'h3004) begin failures++; $display("FAIL ret_pc got=%h exp=3004", pc); end
    checks++; if (ras_count !== 4'd0) begin failures++; $display("FAIL ret_count got=%0d exp=0", ras_count); end
  endtask

  task automatic test_overflow();
    logic [31:0] links[9];
    drive(3'd0, 1'b0, 26'd0, 32'd0, 1'b0, 1'b1); tick();
    for (int i = 0; i < 9; i++) begin
      links[i] = pc + 32'd4;
      drive(3'd3, 1'b0, 26'($urandom_range(26'h3FFFFFF, 0)), 32'd0, 1'b0, 1'b0); tick();
    end
    checks++; if (ras_count !== 4'd8) begin failures++; $display("FAIL ovf_count got=%0d exp=8", ras_count); end
    checks++; if (ras_overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", ras_overflow); end
    for (int i = 8; i >= 1; i--) begin
      drive(3'd5, 1'b0, 26'd0, links[i], 1'b0, 1'b0);
      checks++; if (ret_pred !== links[i]) begin failures++; $display("FAIL lifo%0d got=%h exp=%h", i, ret_pred, links[i]); end
      checks++; if (ret_mispredict !== 1'b0) begin failures++; $display("FAIL lifo_mp%0d got=%b exp=0", i, ret_mispredict); end
      tick();
    end
    drive(3'd5, 1'b0, 26'd0, 32'h0, 1'b0, 1'b0);
    checks++; if (ret_mispredict !== 1'b1) begin failures++; $display("FAIL empty_mp got=%b exp=1", ret_mispredict); end
    checks++; if (ret_pred !== 32'd0) begin failures++; $display("FAIL empty_pred got=%h exp=0", ret_pred); end
    tick();
    checks++; if (ras_count !== 4'd0) begin failures++; $display("FAIL empty_count got=%0d exp=0", ras_count); end
    checks++; if (ras_overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", ras_overflow); end
  endtask

  task automatic test_mispredict();
    logic [31:0] bad;
    drive(3'd3, 1'b0, 26'h0000100, 32'd0, 1'b0, 1'b0); tick();
    drive(3'd3, 1'b0, 26'h0000200, 32'd0, 1'b0, 1'b0); tick();
    bad = ret_pred ^ 32'h0000_0010;
    drive(3'd5, 1'b0, 26'd0, bad, 1'b0, 1'b0);
    checks++; if (ret_mispredict !== 1'b1) begin failures++; $display("FAIL mp_flag got=%b exp=1", ret_mispredict); end
    tick();
    checks++; if (pc !== bad) begin failures++; $display("FAIL mp_pc got=%h exp=%h", pc, bad); end
    checks++; if (ras_count !== 4'd1) begin failures++; $display("FAIL mp_pop got=%0d exp=1", ras_count); end
    drive(3'd5, 1'b0, 26'd0, 32'h1234_5678, 1'b1, 1'b0); tick();
    checks++; if (ras_count !== 4'd1) begin failures++; $display("FAIL stall_pop got=%0d exp=1", ras_count); end
    checks++; if (pc !== bad) begin failures++; $display("FAIL stall_ret_pc got=%h exp=%h", pc, bad); end
    drive(3'd4, 1'b0, 26'd0, 32'h0000_4000, 1'b0, 1'b0); tick();
    checks++; if (ras_count !== 4'd1) begin failures++; $display("FAIL jr_nopop got=%0d exp=1", ras_count); end
  endtask

  task automatic test_reset_mid();
    drive(3'd0, 1'b0, 26'd0, 32'd0, 1'b0, 1'b1); tick();
    for (int i = 0; i < 9; i++) begin drive(3'd3, 1'b0, 26'(i * 16), 32'd0, 1'b0, 1'b0); tick(); end
    for (int i = 0; i < 5; i++) begin drive(3'd5, 1'b0, 26'd0, 32'd0, 1'b0, 1'b0); tick(); end
    checks++; if (ras_count !== 4'd3) begin failures++; $display("FAIL mid_pre got=%0d exp=3", ras_count); end
    drive(3'd3, 1'b0, 26'h0000C10, 32'd0, 1'b1, 1'b1); tick();
    checks++; if (pc !== 32'h3000) begin failures++; $display("FAIL mid_pc got=%h exp=3000", pc); end
    checks++; if (ras_count !== 4'd0) begin failures++; $display("FAIL mid_count got=%0d exp=0", ras_count); end
    checks++; if (ras_overflow !== 1'b0) begin failures++; $display("FAIL mid_ovf got=%b exp=0", ras_overflow); end
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] rs;
    for (int n = 0; n < 400; n++) begin
      o  = 3'($urandom_range(7, 0));
      rs = ($urandom_range(1, 0) == 1) ? m_top() : $urandom;
      drive(o, 1'($urandom), 26'($urandom), rs, ($urandom_range(7, 0) == 0), ($urandom_range(49, 0) == 0));
      checks++; if (next_pc !== m_target()) begin failures++; $display("FAIL rnd_npc n=%0d got=%h exp=%h", n, next_pc, m_target()); end
      checks++; if (pc4 !== m_pc + 32'd4) begin failures++; $display("FAIL rnd_pc4 n=%0d got=%h exp=%h", n, pc4, m_pc + 32'd4); end
      checks++; if (ret_pred !== m_top()) begin failures++; $display("FAIL rnd_pred n=%0d got=%h exp=%h", n, ret_pred, m_top()); end
      checks++; if (ret_mispredict !== m_mispred()) begin failures++; $display("FAIL rnd_mp n=%0d got=%b exp=%b", n, ret_mispredict, m_mispred()); end
      tick();
      checks++; if (pc !== m_pc) begin failures++; $display("FAIL rnd_pc n=%0d got=%h exp=%h", n, pc, m_pc); end
      checks++; if (ras_count !== 4'(m_stk.size())) begin failures++; $display("FAIL rnd_cnt n=%0d got=%0d exp=%0d", n, ras_count, m_stk.size()); end
      checks++; if (ras_overflow !== m_ovf) begin failures++; $display("FAIL rnd_ovf n=%0d got=%b exp=%b", n, ras_overflow, m_ovf); end
    end
  endtask

  initial begin
    m_pc = 32'h3000; m_ovf = 1'b0;
    test_reset();
    test_seq_stall();
    test_branch();
    test_jumps();
    test_overflow();
    test_mispredict();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
